fft32_stage_ctrl: RTL and testbench

Sequencer for the 32-point radix-2 DIT FFT datapath. It sits between the in-place sample RAM and the butterfly/adder pipeline.
- On start, walks log2(N) stages of N/2 butterflies, one per cycle.
- Issues RAM read-pair addresses and twiddle indices, then the matching write-back addresses delayed by the butterfly pipeline latency.
- Inserts drain cycles between stages to avoid read-after-write hazards.
- Input data is already in bit-reversed order in RAM; this block does no reordering.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_bf_addr_gen.sv | 34 +++
 rtl/fft32_stage_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fft32_stage_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared sizing and state encoding for the 32-point radix-2 DIT FFT sequencer.
package fft_pkg;

    localparam int N_LOG2 = 5;
    localparam int N      = 1 << N_LOG2;
    localparam int NBF    = N / 2;

    localparam int ADDR_W = N_LOG2;
    localparam int TW_W   = N_LOG2 - 1;
    localparam int BFK_W  = N_LOG2 - 1;
    localparam int STG_W  = $clog2(N_LOG2);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [TW_W-1:0]   tw_t;
    typedef logic [BFK_W-1:0]  bfk_t;
    typedef logic [STG_W-1:0]  stg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Maps (stage s, butterfly k) to operand addresses a, b = a + 2^s and twiddle index.
module fft_bf_addr_gen
    import fft_pkg::*;
(
    input  logic [STG_W-1:0]  stage,
    input  logic [BFK_W-1:0]  k,
    output logic [ADDR_W-1:0] a,
    output logic [ADDR_W-1:0] b,
    output logic [TW_W-1:0]   tw
);

    localparam addr_t ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam stg_t  STG_ONE  = {{(STG_W-1){1'b0}}, 1'b1};
    localparam stg_t  TW_TOP   = stg_t'(TW_W);

    addr_t k_ext_s;
    addr_t h_s;
    addr_t j_s;
    addr_t a_s;
    addr_t tw_full_s;

    // Group base is (k >> s) * 2h, offset within group is k mod h.
    always_comb begin
        k_ext_s   = {1'b0, k};
        h_s       = ADDR_ONE << stage;
        j_s       = k_ext_s & (h_s - ADDR_ONE);
        a_s       = ((k_ext_s >> stage) << (stage + STG_ONE)) | j_s;
        tw_full_s = j_s << (TW_TOP - stage);
        a         = a_s;
        b         = a_s + h_s;
        tw        = tw_full_s[TW_W-1:0];
    end

endmodule

// File: rtl/fft32_stage_ctrl.sv
// FFT stage sequencer: issues one butterfly read per cycle, delays it by BF_LAT
// for write-back, and drains BF_LAT cycles between stages. Registers on falling edge.
module fft32_stage_ctrl
    import fft_pkg::*;
#(
    parameter int BF_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [STG_W-1:0]  stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    localparam int DRN_W = 3;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(BF_LAT - 1);
    localparam logic [DRN_W-1:0] DRN_ONE  = {{(DRN_W-1){1'b0}}, 1'b1};
    localparam bfk_t K_LAST   = bfk_t'(NBF - 1);
    localparam bfk_t BFK_ONE  = {{(BFK_W-1){1'b0}}, 1'b1};
    localparam stg_t STG_LAST = stg_t'(N_LOG2 - 1);
    localparam stg_t STG_ONE  = {{(STG_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    bfk_t              k_r, k_s;
    stg_t              stage_r, stage_s;
    logic [DRN_W-1:0]  drain_r, drain_s;

    addr_t gen_a_s, gen_b_s;
    tw_t   gen_tw_s;

    logic  rd_en_s, busy_s, done_s;
    addr_t rd_a_s, rd_b_s;
    tw_t   tw_s;
    stg_t  stage_o_s;

    logic [BF_LAT-1:0] dl_en_r;
    addr_t             dl_a_r [BF_LAT];
    addr_t             dl_b_r [BF_LAT];

    fft_bf_addr_gen u_addr_gen (
        .stage (stage_r),
        .k     (k_r),
        .a     (gen_a_s),
        .b     (gen_b_s),
        .tw    (gen_tw_s)
    );

    // Next-state, counter and next-output decode; outputs reflect the current state.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        stage_s   = stage_r;
        drain_s   = drain_r;
        rd_en_s   = 1'b0;
        rd_a_s    = '0;
        rd_b_s    = '0;
        tw_s      = '0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        stage_o_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    k_s     = '0;
                    stage_s = '0;
                    drain_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                rd_en_s   = 1'b1;
                rd_a_s    = gen_a_s;
                rd_b_s    = gen_b_s;
                tw_s      = gen_tw_s;
                busy_s    = 1'b1;
                stage_o_s = stage_r;
                if (k_r == K_LAST) begin
                    state_s = ST_DRAIN;
                    k_s     = '0;
                    drain_s = '0;
                end else begin
                    k_s = k_r + BFK_ONE;
                end
            end
            ST_DRAIN: begin
                busy_s    = 1'b1;
                stage_o_s = stage_r;
                if (drain_r == DRN_LAST) begin
                    drain_s = '0;
                    if (stage_r == STG_LAST) begin
                        state_s = ST_FIN;
                        stage_s = '0;
                    end else begin
                        state_s = ST_RUN;
                        stage_s = stage_r + STG_ONE;
                    end
                end else begin
                    drain_s = drain_r + DRN_ONE;
                end
            end
            ST_FIN: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered read-side outputs.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            k_r       <= '0;
            stage_r   <= '0;
            drain_r   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            stage_r   <= stage_s;
            drain_r   <= drain_s;
            busy      <= busy_s;
            done      <= done_s;
            stage     <= stage_o_s;
            rd_en     <= rd_en_s;
            rd_addr_a <= rd_a_s;
            rd_addr_b <= rd_b_s;
            tw_idx    <= tw_s;
        end
    end

    // Write-back delay line: the read strobe and addresses reappear BF_LAT edges later.
    always_ff @(negedge clk) begin
        if (!rst) begin
            dl_en_r <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                dl_a_r[i] <= '0;
                dl_b_r[i] <= '0;
            end
        end else begin
            dl_en_r[0] <= rd_en;
            dl_a_r[0]  <= rd_addr_a;
            dl_b_r[0]  <= rd_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_en_r[i] <= dl_en_r[i-1];
                dl_a_r[i]  <= dl_a_r[i-1];
                dl_b_r[i]  <= dl_b_r[i-1];
            end
        end
    end

    assign wr_en     = dl_en_r[BF_LAT-1];
    assign wr_addr_a = dl_a_r[BF_LAT-1];
    assign wr_addr_b = dl_b_r[BF_LAT-1];

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// Bench for fft32_stage_ctrl at BF_LAT=2 and BF_LAT=4 against a timeline model
// derived from start-edge offsets and the butterfly address formulas.
module tb_fft32_stage_ctrl;
    import fft_pkg::*;

    localparam int LAT0 = 2;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;

    logic              b0_busy, b0_done, b0_rd, b0_wr;
    logic [STG_W-1:0]  b0_stage;
    logic [ADDR_W-1:0] b0_ra, b0_rb, b0_wa, b0_wb;
    logic [TW_W-1:0]   b0_tw;
    logic              b1_busy, b1_done, b1_rd, b1_wr;
    logic [STG_W-1:0]  b1_stage;
    logic [ADDR_W-1:0] b1_ra, b1_rb, b1_wa, b1_wb;
    logic [TW_W-1:0]   b1_tw;

    fft32_stage_ctrl #(.BF_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(b0_busy), .done(b0_done),
        .stage(b0_stage), .rd_en(b0_rd), .rd_addr_a(b0_ra), .rd_addr_b(b0_rb),
        .tw_idx(b0_tw), .wr_en(b0_wr), .wr_addr_a(b0_wa), .wr_addr_b(b0_wb)
    );

    fft32_stage_ctrl #(.BF_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(b1_busy), .done(b1_done),
        .stage(b1_stage), .rd_en(b1_rd), .rd_addr_a(b1_ra), .rd_addr_b(b1_rb),
        .tw_idx(b1_tw), .wr_en(b1_wr), .wr_addr_a(b1_wa), .wr_addr_b(b1_wb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    int active [2];
    int t0     [2];
    int touch  [2][N_LOG2][N];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Slot q of a transform: stage q / P, butterfly q mod P; slots past NBF are drain.
    task automatic ref_slot(input int q, input int p, output int v, output int a,
                            output int b, output int tw);
        int s, k, h, j;
        s = q / p;
        k = q % p;
        v = 0; a = 0; b = 0; tw = 0;
        if (k < NBF) begin
            h  = 2 ** s;
            j  = k % h;
            v  = 1;
            a  = (k / h) * 2 * h + j;
            b  = a + h;
            tw = j * (NBF / h);
        end
    endtask

    task automatic model_and_check(input int d, input int lat,
            input logic o_busy, input logic o_done, input logic [STG_W-1:0] o_stage,
            input logic o_rd, input logic [ADDR_W-1:0] o_ra, input logic [ADDR_W-1:0] o_rb,
            input logic [TW_W-1:0] o_tw, input logic o_wr,
            input logic [ADDR_W-1:0] o_wa, input logic [ADDR_W-1:0] o_wb);
        int p, t_done, r, ok, dummy;
        int e_busy, e_done, e_stage, e_rd, e_ra, e_rb, e_tw, e_wr, e_wa, e_wb;
        string pre;
        pre = (d == 0) ? "L2 " : "L4 ";
        p = NBF + lat;
        t_done = N_LOG2 * p + 1;
        e_busy = 0; e_done = 0; e_stage = 0; e_rd = 0; e_ra = 0; e_rb = 0;
        e_tw = 0; e_wr = 0; e_wa = 0; e_wb = 0;
        if (!rst) begin
            active[d] = 0;
        end else begin
            if (active[d] != 0 && edge_no - t0[d] > t_done) active[d] = 0;
            if (active[d] == 0 && start) begin
                active[d] = 1;
                t0[d] = edge_no;
                for (int s = 0; s < N_LOG2; s++)
                    for (int x = 0; x < N; x++) touch[d][s][x] = 0;
            end
            if (active[d] != 0) begin
                r = edge_no - t0[d];
                if (r >= 1 && r <= t_done - 1) begin
                    e_busy  = 1;
                    e_stage = (r - 1) / p;
                    ref_slot(r - 1, p, e_rd, e_ra, e_rb, e_tw);
                    if (r - lat >= 1) ref_slot(r - lat - 1, p, e_wr, e_wa, e_wb, dummy);
                end else if (r == t_done) begin
                    e_done = 1;
                end
            end
        end
        check_val({pre, "busy"}, 32'(o_busy), e_busy);
        check_val({pre, "done"}, 32'(o_done), e_done);
        if (e_busy != 0 || !rst) check_val({pre, "stage"}, 32'(o_stage), e_stage);
        check_val({pre, "rd_en"}, 32'(o_rd), e_rd);
        check_val({pre, "rd_addr_a"}, 32'(o_ra), e_ra);
        check_val({pre, "rd_addr_b"}, 32'(o_rb), e_rb);
        check_val({pre, "tw_idx"}, 32'(o_tw), e_tw);
        check_val({pre, "wr_en"}, 32'(o_wr), e_wr);
        check_val({pre, "wr_addr_a"}, 32'(o_wa), e_wa);
        check_val({pre, "wr_addr_b"}, 32'(o_wb), e_wb);
        if (e_rd != 0 && o_rd === 1'b1 && e_stage < N_LOG2) begin
            touch[d][e_stage][o_ra]++;
            touch[d][e_stage][o_rb]++;
        end
        if (e_done != 0) begin
            for (int s = 0; s < N_LOG2; s++) begin
                ok = 1;
                for (int x = 0; x < N; x++) if (touch[d][s][x] != 1) ok = 0;
                check_val({pre, "stage_cover"}, ok, 1);
            end
        end
    endtask

    task automatic tick(input logic st, input logic rs);
        start = st;
        rst   = rs;
        @(negedge clk);
        edge_no++;
        @(posedge clk);
        model_and_check(0, LAT0, b0_busy, b0_done, b0_stage, b0_rd, b0_ra, b0_rb,
                        b0_tw, b0_wr, b0_wa, b0_wb);
        model_and_check(1, LAT1, b1_busy, b1_done, b1_stage, b1_rd, b1_ra, b1_rb,
                        b1_tw, b1_wr, b1_wa, b1_wb);
    endtask

    initial begin
        active[0] = 0; active[1] = 0; t0[0] = 0; t0[1] = 0;
        rst = 1'b0;
        start = 1'b0;
        repeat (3) tick(1'b0, 1'b0);

        // Single start pulse, full transform.
        tick(1'b1, 1'b1);
        repeat (110) tick(1'b0, 1'b1);

        // Pulses at offsets 10 and 91 must be ignored.
        for (int r = 0; r < 112; r++) tick((r == 0) || (r == 10) || (r == 91), 1'b1);

        // Start held high: back-to-back transforms.
        repeat (200) tick(1'b1, 1'b1);
        repeat (120) tick(1'b0, 1'b1);

        // Reset during stage 2 then a fresh transform.
        tick(1'b1, 1'b1);
        for (int r = 1; r < 40; r++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        repeat (110) tick(1'b0, 1'b1);

        // Random starts with occasional reset.
        repeat (4000) tick($urandom_range(0, 24) == 0, $urandom_range(0, 399) != 0);
        repeat (110) tick(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
